// File: rtl/sseg_pkg.sv
// Shared constants for the 7-segment shift sequencer: state encoding,
// default geometry and a ceiling-log2 helper for counter sizing.
package sseg_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_SHIFT_LO = 3'd1;
    localparam logic [STATE_W-1:0] ST_SHIFT_HI = 3'd2;
    localparam logic [STATE_W-1:0] ST_LATCH    = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;

    localparam int unsigned DEF_DATA_W  = 64;
    localparam int unsigned DEF_CLK_DIV = 2;
    localparam int unsigned DEF_LAT_CYC = 1;

    // Smallest r with 2**r >= value
    function automatic int unsigned sseg_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sseg_phase_cnt.sv
// Loadable down-counter; o_tc_c flags the last cycle of a loaded interval.
// Loading N-1 yields an interval of exactly N cycles.
module sseg_phase_cnt
    import sseg_pkg::*;
#(
    parameter int unsigned W = sseg_clog2(DEF_CLK_DIV + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc_c
);

    logic [W-1:0] r_cnt;

    // Count down to zero and hold; a load always wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/sseg_shift_ctrl.sv
// Serialises a segment map MSB first into cascaded 7-segment shift
// registers, then strobes the storage latch. Optional build macro
// SSEG_AUTO_REFRESH_EN starts a frame whenever seg_map differs from the
// last transmitted value.
module sseg_shift_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned LAT_CYC = DEF_LAT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] seg_map,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              seg_sclk,
    output logic              seg_sdat,
    output logic              seg_lat,
    output logic              seg_en
);

    localparam int unsigned PH_MAX = (CLK_DIV > LAT_CYC) ? CLK_DIV : LAT_CYC;
    localparam int unsigned CNT_W  = sseg_clog2(PH_MAX + 1);
    localparam int unsigned BIT_W  = sseg_clog2(DATA_W);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LAT_CYC - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

    logic [STATE_W-1:0] r_state;
    logic [BIT_W-1:0]   r_bit;
    logic [DATA_W-1:0]  r_shreg;
    logic               r_busy;
    logic               r_done;
    logic               r_sclk;
    logic               r_sdat;
    logic               r_lat;
    logic               r_en;

    logic [STATE_W-1:0] w_state_nxt;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic [DATA_W-1:0]  w_shreg_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_sclk_nxt;
    logic               w_sdat_nxt;
    logic               w_lat_nxt;
    logic               w_en_nxt;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_val;
    logic               w_tc;
    logic               w_go;

`ifdef SSEG_AUTO_REFRESH_EN
    logic [DATA_W-1:0]  r_last;
    logic               w_accept;

    assign w_go     = start | (seg_map != r_last);
    assign w_accept = (r_state == ST_IDLE) && w_go;

    // Remember the map of the most recently accepted frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
        end else if (w_accept) begin
            r_last <= seg_map;
        end
    end
`else
    assign w_go = start;
`endif

    sseg_phase_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_tc_c     (w_tc)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bit   <= '0;
            r_shreg <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdat  <= 1'b0;
            r_lat   <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_sclk  <= w_sclk_nxt;
            r_sdat  <= w_sdat_nxt;
            r_lat   <= w_lat_nxt;
            r_en    <= w_en_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_sclk_nxt  = r_sclk;
        w_sdat_nxt  = r_sdat;
        w_lat_nxt   = r_lat;
        w_en_nxt    = r_en;
        w_cnt_load  = 1'b0;
        w_cnt_val   = HALF_LOAD;

        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_shreg_nxt = seg_map;
                    w_sdat_nxt  = seg_map[DATA_W-1];
                    w_bit_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_state_nxt = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (w_tc) begin
                    w_sclk_nxt  = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_state_nxt = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (w_tc) begin
                    w_sclk_nxt = 1'b0;
                    w_cnt_load = 1'b1;
                    if (r_bit < LAST_BIT) begin
                        // Rotate rather than shift: only the top bit is ever presented
                        w_shreg_nxt = {r_shreg[DATA_W-2:0], r_shreg[DATA_W-1]};
                        w_sdat_nxt  = r_shreg[DATA_W-2];
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_state_nxt = ST_SHIFT_LO;
                    end else begin
                        w_lat_nxt   = 1'b1;
                        w_sdat_nxt  = 1'b0;
                        w_cnt_val   = LAT_LOAD;
                        w_state_nxt = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (w_tc) begin
                    w_lat_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_en_nxt    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign seg_sclk = r_sclk;
    assign seg_sdat = r_sdat;
    assign seg_lat  = r_lat;
    assign seg_en   = r_en;

endmodule

// File: tb/tb_sseg_shift_ctrl.sv
// Self-checking bench for sseg_shift_ctrl. A pin-level monitor rebuilds the
// latched frame from sclk rising edges and compares it with the frames the
// bench expects the display to receive.
module tb_sseg_shift_ctrl;

    localparam int unsigned DW      = 64;
    localparam int unsigned CD      = 2;
    localparam int unsigned LC      = 1;
    localparam int          LAT_EXP = 2 * DW * CD + LC;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seg_map;
    logic          busy;
    logic          done;
    logic          seg_sclk;
    logic          seg_sdat;
    logic          seg_lat;
    logic          seg_en;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0, acc_cyc = 0, last_done_cyc = 0, last_gap = -1, last_edge_cyc = 0;
    int edges = 0, total_edges = 0, run_len = 0, lat_run = 0;
    int hp_err = 0, sdat_err = 0, lat_sclk_err = 0;
    int accepts = 0, dones = 0, lat_pulses = 0;
    bit have_done = 1'b0;
    logic prev_sclk = 1'b0, prev_sdat = 1'b0, prev_lat = 1'b0, prev_busy = 1'b0;

    logic          bits_q[$];
    logic [DW-1:0] exp_q[$];

    sseg_shift_ctrl #(
        .DATA_W  (DW),
        .CLK_DIV (CD),
        .LAT_CYC (LC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_map  (seg_map),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .seg_sclk (seg_sclk),
        .seg_sdat (seg_sdat),
        .seg_lat  (seg_lat),
        .seg_en   (seg_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and observe the pins
    task automatic tick();
        logic [DW-1:0] got;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            run_len = 0;
            lat_run = 0;
            edges   = 0;
            bits_q.delete();
        end else begin
            if (busy && !prev_busy) begin
                accepts++;
                acc_cyc = cyc;
                edges   = 0;
                bits_q.delete();
                if (have_done) last_gap = cyc - last_done_cyc - 1;
            end
            if (seg_sclk != prev_sclk) begin
                if (seg_sclk) begin
                    if (edges > 0 && run_len != CD) hp_err++;
                    edges++;
                    total_edges++;
                    last_edge_cyc = cyc;
                    bits_q.push_back(seg_sdat);
                end else if (run_len != CD) begin
                    hp_err++;
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            if (seg_sclk && seg_sdat != prev_sdat) sdat_err++;
            if (seg_lat && seg_sclk) lat_sclk_err++;
            if (seg_lat && !prev_lat) begin
                lat_pulses++;
                chk("frame_len", 64'(bits_q.size()), 64'(DW));
                got = '0;
                for (int i = 0; i < bits_q.size() && i < DW; i++) got[DW-1-i] = bits_q[i];
                if (exp_q.size() == 0) chk("unexpected_latch", 64'(1), 64'(0));
                else chk("frame_data", got, exp_q.pop_front());
                chk("lat_after_edge", 64'(cyc - last_edge_cyc), 64'(CD));
                bits_q.delete();
            end
            if (seg_lat) begin
                lat_run++;
            end else if (prev_lat) begin
                chk("lat_width", 64'(lat_run), 64'(LC));
                lat_run = 0;
            end
            if (done) begin
                dones++;
                chk("done_latency", 64'(cyc - acc_cyc), 64'(LAT_EXP));
                chk("done_busy_low", 64'(busy), 64'(0));
                last_done_cyc = cyc;
                have_done     = 1'b1;
            end
        end
        prev_sclk = seg_sclk;
        prev_sdat = seg_sdat;
        prev_lat  = seg_lat;
        prev_busy = busy;
    endtask

    task automatic wait_dones(input int target, input int budget);
        for (int i = 0; i < budget && dones < target; i++) tick();
        chk("wait_done", 64'(dones), 64'(target));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_sclk"}, 64'(seg_sclk), 64'(0));
        chk({tag, "_sdat"}, 64'(seg_sdat), 64'(0));
        chk({tag, "_lat"}, 64'(seg_lat), 64'(0));
        chk({tag, "_en"}, 64'(seg_en), 64'(0));
    endtask

    initial begin
        logic [DW-1:0] v;
        int a0, d0, lp0;

        rst     = 1'b1;
        start   = 1'b0;
        seg_map = '0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (20) tick();
        chk_all_zero("idle");
        chk("idle_sclk_edges", 64'(total_edges), 64'(0));

        // Single frame with only the end bits set
        seg_map = 64'h8000_0000_0000_0001;
        exp_q.push_back(seg_map);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_dones(1, 400);
        chk("single_edges", 64'(edges), 64'(DW));
        chk("single_en", 64'(seg_en), 64'(1));
        chk("single_sdat_rest", 64'(seg_sdat), 64'(0));

        // Start held: back-to-back frames
        seg_map = 64'hA5A5_5A5A_F00F_0FF0;
        exp_q.push_back(seg_map);
        exp_q.push_back(seg_map);
        a0 = accepts;
        d0 = dones;
        start = 1'b1;
        for (int i = 0; i < 600 && accepts < a0 + 2; i++) tick();
        start = 1'b0;
        chk("held_accepts", 64'(accepts), 64'(a0 + 2));
        chk("held_gap", 64'(last_gap), 64'(1));
        wait_dones(d0 + 2, 700);
        repeat (20) tick();
        chk("held_no_third", 64'(accepts), 64'(a0 + 2));

        // Random frames with a stray start and map change mid-frame
        for (int k = 0; k < 3; k++) begin
            v = {$urandom(), $urandom()};
            seg_map = v;
            exp_q.push_back(v);
            a0 = accepts;
            d0 = dones;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (49) tick();
            seg_map = {$urandom(), $urandom()};
            start = 1'b1;
            tick();
            start = 1'b0;
`ifdef SSEG_AUTO_REFRESH_EN
            if (seg_map != v) begin
                exp_q.push_back(seg_map);
                wait_dones(d0 + 2, 800);
                a0 = a0 + 1;
            end else begin
                wait_dones(d0 + 1, 400);
            end
`else
            wait_dones(d0 + 1, 400);
`endif
            repeat (20) tick();
            chk("midframe_no_requeue", 64'(accepts), 64'(a0 + 1));
        end

        // Reset at the 30th sclk edge, then a clean frame
        v = {$urandom(), $urandom()};
        seg_map = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lp0 = lat_pulses;
        for (int i = 0; i < 400 && edges < 30; i++) tick();
        chk("abort_reach_edge30", 64'(edges), 64'(30));
        rst     = 1'b1;
        seg_map = '0;
        tick();
        chk_all_zero("abort");
        rst = 1'b0;
        repeat (5) tick();
        chk("abort_no_latch", 64'(lat_pulses), 64'(lp0));
        chk("abort_en_low", 64'(seg_en), 64'(0));
        v = {$urandom(), $urandom()};
        seg_map = v;
        exp_q.push_back(v);
        d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_dones(d0 + 1, 400);
        chk("abort_recover_latch", 64'(lat_pulses), 64'(lp0 + 1));
        chk("abort_recover_en", 64'(seg_en), 64'(1));

`ifdef SSEG_AUTO_REFRESH_EN
        // Auto refresh: a change alone launches a frame, no change stays quiet
        rst     = 1'b1;
        seg_map = '0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        a0 = accepts;
        d0 = dones;
        seg_map = 64'h1;
        exp_q.push_back(seg_map);
        tick();
        chk("auto_start", 64'(busy), 64'(1));
        wait_dones(d0 + 1, 400);
        repeat (1000) tick();
        chk("auto_quiet", 64'(accepts), 64'(a0 + 1));
`endif

        chk("sclk_half_period", 64'(hp_err), 64'(0));
        chk("sdat_stable_high", 64'(sdat_err), 64'(0));
        chk("lat_sclk_low", 64'(lat_sclk_err), 64'(0));
        chk("frames_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sseg_shift_ctrl.md
Name: sseg_shift_ctrl

Overview:
- Sequencer that serially shifts a 64-bit segment map into the board's cascaded 7-segment shift registers, MSB first.
- Generates the serial clock, serial data and latch strobe for those registers.
- Sits directly downstream of the display-number-to-segment mapper, upstream of the board pins.
- Offers a start/busy/done handshake to the display top-level and gates display enable until the first valid frame has been latched.

Parameters:
- DATA_W, 64, number of bits shifted per frame; must be ≥2.
- CLK_DIV, 2, serial-clock half-period in clk cycles; must be ≥1.
- LAT_CYC, 1, latch strobe width in clk cycles; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_map  in  DATA_W  parallel segment pattern; sampled only when a frame starts.
- start  in  1  request to transmit seg_map; level-sampled in IDLE only.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a frame has been latched.
- seg_sclk  out  1  serial clock to the shift registers.
- seg_sdat  out  1  serial data; changes only while seg_sclk is low.
- seg_lat  out  1  latch/storage strobe, active high.
- seg_en  out  1  display enable; 0 until the first frame completes, then 1.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: busy, done, seg_sclk, seg_sdat, seg_lat and seg_en are all 0. State is IDLE and all counters are 0.
- States:
  - IDLE: wait for start.
  - SHIFT_LO: sclk low, data set up.
  - SHIFT_HI: sclk high, data held.
  - LATCH: lat high, sclk low.
  - DONE: single cycle.
- IDLE, start=1 at edge E0:
  - seg_map is copied to an internal shift register.
  - State becomes SHIFT_LO; busy=1.
  - seg_sdat = seg_map[DATA_W-1]; bit counter = 0; phase counter = 0.
- SHIFT_LO lasts CLK_DIV cycles, then goes to SHIFT_HI with seg_sclk=1. seg_sdat is unchanged.
- SHIFT_HI lasts CLK_DIV cycles. On exit, seg_sclk=0, and then:
  - If bit counter < DATA_W-1: shift left, present the next bit on seg_sdat, bit counter +1, return to SHIFT_LO.
  - Else: go to LATCH with seg_lat=1 and seg_sdat=0.
- LATCH lasts LAT_CYC cycles, then goes to DONE with seg_lat=0.
- DONE, one cycle: done=1, busy=0, seg_en=1 (sticky until rst). Next state is IDLE.
- Latency:
  - done is high in the cycle following edge E0 + 2·DATA_W·CLK_DIV + LAT_CYC.
  - Defaults give 257 cycles.
  - Back-to-back frames: start held high in IDLE re-arms one cycle after DONE.
- Data ownership:
  - Changes to seg_map while busy are ignored; the frame uses the captured value.
  - start while busy or in DONE is dropped. No queueing in the base build.
- Reset mid-frame:
  - Abort at the next edge and drive all outputs to reset values.
  - seg_lat must not pulse, so the previously latched display content is preserved.
  - seg_en returns to 0.
- Counter widths: bit counter is clog2(DATA_W) bits; phase counter is clog2(max(CLK_DIV,LAT_CYC)+1) bits. No wrap beyond terminal counts.

Optional Feature:
- Macro: SSEG_AUTO_REFRESH_EN.
- Defined:
  - A register holds the last transmitted seg_map.
  - In IDLE, a frame starts automatically when seg_map differs from that register, or when start=1.
  - The register is updated at frame acceptance and reset to all-zeros.
  - Consequence: the first non-zero seg_map after reset transmits with no start.
  - A change while busy is picked up in the first IDLE cycle after DONE.
- Undefined: frames start only on start; no comparison register exists.

Decomposition:
- Shared package sseg_pkg:
  - State encoding localparams (IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE).
  - Default DATA_W/CLK_DIV/LAT_CYC constants.
  - clog2 helper function.
- One natural sub-module, sseg_phase_cnt: a loadable down-counter producing a terminal-count tick, reused for the shift half-periods and the latch width.

Test Plan:
- Reset, then idle 20 cycles -> all outputs 0, seg_en=0, no sclk edges.
- seg_map=64'h8000_0000_0000_0001, start one cycle, defaults ->
  - exactly 64 sclk rising edges, each half-period 2 cycles;
  - sdat=1 at rising edge 1 and edge 64, 0 at all others;
  - lat high 1 cycle after edge 64; done at cycle 257; seg_en=1 afterwards.
- Start held high for 600 cycles, seg_map=64'hA5A5_5A5A_F00F_0FF0 -> two complete frames, bit-exact against a reference shift model; DONE-to-busy gap is 1 cycle.
- start pulsed at cycle 50 of a frame and seg_map changed mid-frame -> no second frame; latched data equals the value captured at acceptance.
- rst asserted at sclk edge 30 -> next cycle all outputs 0; seg_lat never pulses; a new start transmits a full frame correctly.
- SSEG_AUTO_REFRESH_EN: seg_map changes 0 -> 64'h1 with no start -> frame begins next cycle. With seg_map unchanged afterwards -> no further frames for 1000 cycles.
